// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_pkg                                                                 |
// | Shared types, defaults and sizing helpers for the FIFO read-side drain.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`ifndef FIFO_WIDTH
`define FIFO_WIDTH 8
`endif

package fifo_pkg;

    localparam int DEF_WIDTH     = `FIFO_WIDTH;
    localparam int MIN_BUF_DEPTH = 3;
    localparam int MAX_BUF_DEPTH = 16;

    typedef logic [DEF_WIDTH-1:0] word_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Below 3 entries the read pipeline cannot sustain one word per cycle.
    function automatic bit depth_ok(input int depth);
        return (depth >= MIN_BUF_DEPTH) && (depth <= MAX_BUF_DEPTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/drain_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drain_buf                                                                |
// | Circular word buffer with head/tail/occupancy tracking and clear.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module drain_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4,
    parameter int PW    = ptr_w(DEPTH),
    parameter int OW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic [OW-1:0]    count
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [OW-1:0]    occ_q, occ_d;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = bump(tail_q);
            end
            if (pop) begin
                head_d = bump(head_q);
            end
            if (push && !pop) begin
                occ_d = occ_q + OW'(1);
            end else if (!push && pop) begin
                occ_d = occ_q - OW'(1);
            end
        end
    end

    // Storage is reset too so the head word reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign full      = (occ_q == FULL_OCC);
    assign count     = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_drain                                                            |
// | Read-side drain: reads a FIFO without underflow, re-streams valid/ready. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             ren,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] pop_count,
    output logic [7:0]       drop_count
);

    localparam int          OW      = $clog2(BUF_DEPTH + 1);
    localparam logic [OW:0] DEPTH_V = (OW + 1)'(BUF_DEPTH);

    generate
        if (!depth_ok(BUF_DEPTH)) begin : g_bad_depth
            $error("fifo_rd_drain: BUF_DEPTH must be within 3..16");
        end
    endgenerate

    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pop_q, pop_d;
    logic [7:0]       drop_q, drop_d;
    logic [OW-1:0]    occ;
    logic             buf_full;
    logic             hs;
    logic [OW:0]      inflight;
    logic [9:0]       drop_sum;

    // Reads are gated on buffered plus in-flight words so a captured word
    // always has a slot, independent of downstream back-pressure.
    always_comb begin
        inflight = {1'b0, occ} + {{OW{1'b0}}, pend_q};
        ren      = !rst && !empty && !flush && !buf_full && (inflight < DEPTH_V);
        hs       = m_valid && m_ready && !flush;
        pend_d   = ren;
        pop_d    = hs ? pop_q + CNT_W'(1) : pop_q;
        drop_sum = 10'(drop_q) + 10'(inflight);
        drop_d   = drop_q;
        if (flush) begin
            drop_d = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            pend_q <= 1'b0;
            pop_q  <= '0;
            drop_q <= '0;
        end else begin
            pend_q <= pend_d;
            pop_q  <= pop_d;
            drop_q <= drop_d;
        end
    end

    drain_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (rclk),
        .rst       (rst),
        .clear     (flush),
        .push      (pend_q),
        .push_data (rdata),
        .pop       (hs),
        .head_data (m_data),
        .full      (buf_full),
        .count     (occ)
    );

    assign m_valid    = (occ != '0);
    assign pop_count  = pop_q;
    assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_rd_drain                                                         |
// | Directed bench for fifo_rd_drain with a behavioural FIFO read model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fifo_rd_drain;

    logic       clk = 1'b0;
    logic       rst, flush, m_ready, gate_empty;
    logic       empty, ren, m_valid;
    logic [7:0] rdata, m_data, drop_count;
    logic [4:0] pop_count;

    logic [7:0] fq[$];
    logic [7:0] got_q[$];
    int         fcount;
    int         vectors, errors;
    bit         underflow_seen;

    always #5 clk = ~clk;

    assign empty = gate_empty || (fcount == 0);

    fifo_rd_drain #(.WIDTH(8), .BUF_DEPTH(4), .CNT_W(5)) dut (
        .rclk       (clk),
        .rst        (rst),
        .empty      (empty),
        .rdata      (rdata),
        .ren        (ren),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .pop_count  (pop_count),
        .drop_count (drop_count)
    );

    task automatic preload(input int n, input logic [7:0] first);
        for (int k = 0; k < n; k++) fq.push_back(first + 8'(k));
        fcount = fq.size();
    endtask

    // One read-clock cycle: sample, let the edge pass, model the FIFO's
    // registered read data, return at the next falling edge.
    task automatic cyc(output bit r, output bit h);
        #1;
        r = ren;
        h = m_valid && m_ready && !flush;
        if (ren && empty) underflow_seen = 1'b1;
        if (h) got_q.push_back(m_data);
        @(posedge clk);
        #1;
        if (r && fq.size() > 0) rdata = fq.pop_front();
        else rdata = 8'hEE;
        fcount = fq.size();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit r, h;
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; gate_empty = 1'b0;
        preload(16, 8'h01);
        cyc(r, h); cyc(r, h);
        vectors++; if (ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b expected 0", ren); end
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        vectors++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
        vectors++; if (pop_count !== 5'd0) begin errors++; $display("FAIL reset_pop_count: got %0d expected 0", pop_count); end
        vectors++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
    endtask

    task automatic test_stream();
        bit r, h;
        int nren = 0, first_ren = -1, last_ren = -1, first_hs = -1, last_hs = -1;
        got_q.delete();
        rst = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            cyc(r, h);
            if (r) begin nren++; if (first_ren < 0) first_ren = i; last_ren = i; end
            if (h) begin if (first_hs < 0) first_hs = i; last_hs = i; end
        end
        vectors++; if (nren !== 16) begin errors++; $display("FAIL stream_ren_count: got %0d expected 16", nren); end
        vectors++; if (first_ren !== 0 || last_ren !== 15) begin errors++; $display("FAIL stream_ren_span: got %0d..%0d expected 0..15", first_ren, last_ren); end
        vectors++; if (first_hs !== 2 || last_hs !== 17) begin errors++; $display("FAIL stream_out_span: got %0d..%0d expected 2..17", first_hs, last_hs); end
        vectors++; if (got_q.size() !== 16) begin errors++; $display("FAIL stream_word_count: got %0d expected 16", got_q.size()); end
        for (int k = 0; k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== 8'(k + 1)) begin errors++; $display("FAIL stream_word[%0d]: got %h expected %h", k, got_q[k], 8'(k + 1)); end
        end
        vectors++; if (pop_count !== 5'd16) begin errors++; $display("FAIL stream_pop_count: got %0d expected 16", pop_count); end
        vectors++; if (underflow_seen !== 1'b0) begin errors++; $display("FAIL stream_underflow: got 1 expected 0"); end
    endtask

    task automatic test_backpressure();
        bit r, h;
        int nren = 0;
        got_q.delete();
        m_ready = 1'b0;
        preload(10, 8'h01);
        for (int i = 0; i < 10; i++) begin cyc(r, h); if (r) nren++; end
        vectors++; if (nren !== 4) begin errors++; $display("FAIL bp_ren_pulses: got %0d expected 4", nren); end
        vectors++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin errors++; $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=01", m_valid, m_data); end
        m_ready = 1'b1;
        for (int k = 0; k < 40 && got_q.size() < 10; k++) cyc(r, h);
        vectors++; if (got_q.size() !== 10) begin errors++; $display("FAIL bp_word_count: got %0d expected 10", got_q.size()); end
        for (int k = 0; k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== 8'(k + 1)) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", k, got_q[k], 8'(k + 1)); end
        end
        vectors++; if (pop_count !== 5'd26) begin errors++; $display("FAIL bp_pop_count: got %0d expected 26", pop_count); end
    endtask

    task automatic test_empty_gating();
        bit r, h;
        int nren = 0;
        got_q.delete();
        m_ready = 1'b1;
        preload(12, 8'h21);
        for (int i = 0; i < 30; i++) begin
            gate_empty = ((i / 3) % 2 == 0);
            cyc(r, h);
            if (r) nren++;
        end
        gate_empty = 1'b0;
        vectors++; if (nren !== 12) begin errors++; $display("FAIL gate_ren_count: got %0d expected 12", nren); end
        vectors++; if (underflow_seen !== 1'b0) begin errors++; $display("FAIL gate_ren_while_empty: got 1 expected 0"); end
        for (int k = 0; k < 20 && got_q.size() < 12; k++) cyc(r, h);
        vectors++; if (got_q.size() !== 12) begin errors++; $display("FAIL gate_word_count: got %0d expected 12", got_q.size()); end
        for (int k = 0; k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== 8'h21 + 8'(k)) begin errors++; $display("FAIL gate_word[%0d]: got %h expected %h", k, got_q[k], 8'h21 + 8'(k)); end
        end
        vectors++; if (pop_count !== 5'd6) begin errors++; $display("FAIL gate_pop_count: got %0d expected 6", pop_count); end
    endtask

    task automatic test_flush();
        bit r, h;
        got_q.delete();
        m_ready = 1'b0;
        preload(6, 8'h41);
        for (int i = 0; i < 4; i++) cyc(r, h);
        flush = 1'b1; m_ready = 1'b1;
        cyc(r, h);
        flush = 1'b0;
        vectors++; if (r !== 1'b0) begin errors++; $display("FAIL flush_ren: got %b expected 0", r); end
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid: got %b expected 0", m_valid); end
        vectors++; if (drop_count !== 8'd4) begin errors++; $display("FAIL flush_drop_count: got %0d expected 4", drop_count); end
        vectors++; if (pop_count !== 5'd6) begin errors++; $display("FAIL flush_no_handshake: got %0d expected 6", pop_count); end
        for (int k = 0; k < 20 && got_q.size() < 2; k++) cyc(r, h);
        vectors++; if (got_q.size() !== 2) begin errors++; $display("FAIL flush_resume_count: got %0d expected 2", got_q.size()); end
        else begin
            vectors++; if (got_q[0] !== 8'h45 || got_q[1] !== 8'h46) begin errors++; $display("FAIL flush_resume_data: got %h %h expected 45 46", got_q[0], got_q[1]); end
        end
        vectors++; if (pop_count !== 5'd8) begin errors++; $display("FAIL flush_pop_count: got %0d expected 8", pop_count); end
    endtask

    task automatic test_wrap_saturate();
        bit r, h;
        got_q.delete();
        m_ready = 1'b1;
        preload(22, 8'h80);
        for (int k = 0; k < 40 && got_q.size() < 22; k++) cyc(r, h);
        vectors++; if (pop_count !== 5'd30) begin errors++; $display("FAIL wrap_pre: got %0d expected 30", pop_count); end
        preload(3, 8'hA0);
        for (int k = 0; k < 20 && got_q.size() < 25; k++) cyc(r, h);
        vectors++; if (pop_count !== 5'd1) begin errors++; $display("FAIL wrap_post: got %0d expected 1", pop_count); end
        for (int f = 0; f < 74; f++) begin
            m_ready = 1'b0;
            preload(4, 8'hC0);
            for (int i = 0; i < 4; i++) cyc(r, h);
            flush = 1'b1;
            cyc(r, h);
            flush = 1'b0;
            if (f == 61) begin
                vectors++; if (drop_count !== 8'd252) begin errors++; $display("FAIL sat_mid: got %0d expected 252", drop_count); end
            end
        end
        vectors++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", drop_count); end
    endtask

    task automatic test_reset_midstream();
        bit r, h;
        got_q.delete();
        m_ready = 1'b0;
        preload(5, 8'h61);
        for (int i = 0; i < 3; i++) cyc(r, h);
        vectors++; if (m_valid !== 1'b1 || m_data !== 8'h61) begin errors++; $display("FAIL rstmid_pre: got valid=%b data=%h expected valid=1 data=61", m_valid, m_data); end
        rst = 1'b1;
        cyc(r, h);
        vectors++; if (ren !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("FAIL rstmid_outputs: got ren=%b valid=%b data=%h expected 0 0 00", ren, m_valid, m_data); end
        vectors++; if (pop_count !== 5'd0 || drop_count !== 8'd0) begin errors++; $display("FAIL rstmid_counts: got pop=%0d drop=%0d expected 0 0", pop_count, drop_count); end
        rst = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 20 && got_q.size() < 2; k++) cyc(r, h);
        vectors++; if (got_q.size() !== 2) begin errors++; $display("FAIL rstmid_resume_count: got %0d expected 2", got_q.size()); end
        else begin
            vectors++; if (got_q[0] !== 8'h64 || got_q[1] !== 8'h65) begin errors++; $display("FAIL rstmid_resume_data: got %h %h expected 64 65", got_q[0], got_q[1]); end
        end
        vectors++; if (pop_count !== 5'd2 || drop_count !== 8'd0) begin errors++; $display("FAIL rstmid_post_counts: got pop=%0d drop=%0d expected 2 0", pop_count, drop_count); end
    endtask

    initial begin
        vectors = 0; errors = 0; underflow_seen = 1'b0;
        fcount = 0; rdata = 8'hEE;
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; gate_empty = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_gating();
        test_flush();
        test_wrap_saturate();
        test_reset_midstream();
        vectors++; if (underflow_seen !== 1'b0) begin errors++; $display("FAIL final_underflow: got 1 expected 0"); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
